larpix_cfg_packet_builder: RTL and testbench



---
 rtl/larpix_cfg_pkg.sv | 45 ++++
 rtl/larpix_cfg_packet_builder_if.sv | 22 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/larpix_cfg_packet_builder.sv | 183 ++++++++++++++++++
 tb/tb_larpix_cfg_packet_builder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/larpix_cfg_pkg.sv
// Shared definitions for the LArPix configuration packet builder.
//   - packet-declare codes, broadcast chip id, default magic number
//   - FSM state encoding, stored request layout
//   - build_cfg_packet(): formats one request into a 64-bit packet,
//     with odd parity in bit 63.
package larpix_cfg_pkg;

    localparam logic [1:0]  PKT_DATA      = 2'b01;
    localparam logic [1:0]  CFG_WRITE     = 2'b10;
    localparam logic [1:0]  CFG_READ      = 2'b11;
    localparam logic [7:0]  GLOBAL_ID     = 8'd255;
    localparam logic [31:0] DEFAULT_MAGIC = 32'h89504E47;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    typedef struct packed {
        logic       op;          // 0 = config write, 1 = config read
        logic [7:0] chip_id;
        logic [7:0] addr;
        logic [7:0] data;
        logic       bad_parity;  // flips the parity bit for error injection
    } cfg_req_t;

    function automatic logic [63:0] build_cfg_packet(input cfg_req_t req,
                                                     input logic [31:0] magic);
        logic [63:0] pkt;
        pkt          = 64'd0;
        pkt[1:0]     = req.op ? CFG_READ : CFG_WRITE;
        pkt[9:2]     = req.chip_id;
        pkt[17:10]   = req.addr;
        // Reads carry no payload, whatever the requester put on the data lines
        pkt[25:18]   = req.op ? 8'd0 : req.data;
        pkt[57:26]   = magic;
        pkt[62:58]   = 5'd0;
        pkt[63]      = (~^pkt[62:0]) ^ req.bad_parity;
        return pkt;
    endfunction

endpackage

// File: rtl/larpix_cfg_packet_builder_if.sv
// Request channel of the configuration packet builder.
//   master : requester (drives req_valid and the request fields)
//   slave  : packet builder (drives req_ready)
interface larpix_cfg_packet_builder_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_chip_id;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_bad_parity;

    modport master (
        output req_valid, req_op, req_chip_id, req_addr, req_data, req_bad_parity,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_chip_id, req_addr, req_data, req_bad_parity,
        output req_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// Ports: clk/reset (sync, active-high), i_push/i_data write side,
//        i_pop/o_data read side, o_full/o_empty/o_count status.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Entry storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/larpix_cfg_packet_builder.sv
// Command stage in front of the programming UART transmitter.
// Buffers write/read requests, formats each into a 64-bit LArPix config
// packet and hands it to the UART with a one-cycle ld_tx_data strobe,
// then waits for tx_busy to rise and fall before an idle gap.
// Ports: clk, reset (sync, active-high); req_if (slave request channel);
//        tx_data/ld_tx_data/tx_busy UART handshake; idle, fifo_count,
//        pkt_sent_count, timeout_err (sticky), timeout_count (saturating).
module larpix_cfg_packet_builder
    import larpix_cfg_pkg::*;
#(
    parameter int          WIDTH        = 64,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] MAGIC_NUMBER = DEFAULT_MAGIC,
    parameter int          BUSY_TIMEOUT = 16,
    parameter int          GAP_CYCLES   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    larpix_cfg_packet_builder_if.slave   req_if,
    output logic [WIDTH-1:0]             tx_data,
    output logic                         ld_tx_data,
    input  logic                         tx_busy,
    output logic                         idle,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [15:0]                  pkt_sent_count,
    output logic                         timeout_err,
    output logic [7:0]                   timeout_count
);
    localparam int REQ_W = $bits(cfg_req_t);
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_ld_tx_data;
    logic [TW-1:0]    r_to_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [15:0]      r_pkt_sent_count;
    logic             r_timeout_err;
    logic [7:0]       r_timeout_count;

    cfg_req_t         w_req_in;
    cfg_req_t         w_req_out;
    logic [REQ_W-1:0] w_fifo_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_ld_next;
    logic             w_timeout;
    logic             w_sent;
    logic             w_to_done;
    logic             w_gap_done;

    // Pack the request channel into the stored entry layout
    always_comb begin
        w_req_in.op         = req_if.req_op;
        w_req_in.chip_id    = req_if.req_chip_id;
        w_req_in.addr       = req_if.req_addr;
        w_req_in.data       = req_if.req_data;
        w_req_in.bad_parity = req_if.req_bad_parity;
    end

    assign req_if.req_ready = ~w_full;
    assign w_push           = req_if.req_valid & ~w_full;
    assign w_req_out        = w_fifo_rd;

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_req_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // The busy window includes the cycle ld_tx_data is high
    assign w_to_done  = (r_to_cnt == TW'(BUSY_TIMEOUT - 1));
    assign w_gap_done = (r_gap_cnt == GW'(GAP_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_next_state = ST_LOAD;
                else          w_next_state = ST_IDLE;
            end
            ST_LOAD: w_next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy)        w_next_state = ST_WAIT_DONE;
                else if (w_to_done) w_next_state = ST_GAP;
                else                w_next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) w_next_state = ST_GAP;
                else          w_next_state = ST_WAIT_DONE;
            end
            ST_GAP: begin
                if (w_gap_done) w_next_state = ST_IDLE;
                else            w_next_state = ST_GAP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state strobes feeding the registered outputs and counters
    always_comb begin
        w_pop     = 1'b0;
        w_ld_next = 1'b0;
        w_timeout = 1'b0;
        w_sent    = 1'b0;
        case (r_state)
            ST_IDLE:      w_pop     = ~w_empty;
            ST_LOAD:      w_ld_next = 1'b1;
            ST_WAIT_BUSY: w_timeout = ~tx_busy & w_to_done;
            ST_WAIT_DONE: w_sent    = ~tx_busy;
            ST_GAP:       w_pop     = 1'b0;
            default:      w_pop     = 1'b0;
        endcase
    end

    // Packet register, load strobe, timers and status counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data        <= {WIDTH{1'b0}};
            r_ld_tx_data     <= 1'b0;
            r_to_cnt         <= {TW{1'b0}};
            r_gap_cnt        <= {GW{1'b0}};
            r_pkt_sent_count <= 16'd0;
            r_timeout_err    <= 1'b0;
            r_timeout_count  <= 8'd0;
        end else begin
            // tx_data only changes on a pop, so it holds through the whole transfer
            if (w_pop) begin
                r_tx_data <= build_cfg_packet(w_req_out, MAGIC_NUMBER);
            end
            r_ld_tx_data <= w_ld_next;
            if (r_state == ST_LOAD) begin
                r_to_cnt <= {TW{1'b0}};
            end else if (r_state == ST_WAIT_BUSY) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= {GW{1'b0}};
            end
            if (w_sent) begin
                r_pkt_sent_count <= r_pkt_sent_count + 16'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                if (r_timeout_count != 8'hFF) begin
                    r_timeout_count <= r_timeout_count + 8'd1;
                end
            end
        end
    end

    assign tx_data        = r_tx_data;
    assign ld_tx_data     = r_ld_tx_data;
    assign idle           = (r_state == ST_IDLE) & w_empty;
    assign pkt_sent_count = r_pkt_sent_count;
    assign timeout_err    = r_timeout_err;
    assign timeout_count  = r_timeout_count;
endmodule

// File: tb/tb_larpix_cfg_packet_builder.sv
`timescale 1ns/1ps
module tb_larpix_cfg_packet_builder;
    import larpix_cfg_pkg::*;

    localparam int          FIFO_DEPTH   = 8;
    localparam int          BUSY_TIMEOUT = 16;
    localparam int          GAP_CYCLES   = 4;
    localparam logic [31:0] MAGIC        = 32'h89504E47;
    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   tx_data;
    logic          ld_tx_data;
    logic          tx_busy = 1'b0;
    logic          idle;
    logic [CW-1:0] fifo_count;
    logic [15:0]   pkt_sent_count;
    logic          timeout_err;
    logic [7:0]    timeout_count;

    larpix_cfg_packet_builder_if req_if();

    larpix_cfg_packet_builder #(
        .WIDTH(64), .FIFO_DEPTH(FIFO_DEPTH), .MAGIC_NUMBER(MAGIC),
        .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .req_if(req_if),
        .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
        .idle(idle), .fifo_count(fifo_count), .pkt_sent_count(pkt_sent_count),
        .timeout_err(timeout_err), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pkt;
        logic        op;
        logic [7:0]  chip;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        bdp;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   ld_seen = 0;
    int   last_ld_cyc = 0;
    int   max_count = 0;
    int   exp_sent = 0;

    // UART stand-in: accepts a load when not busy, stays busy for a random span
    bit   uart_dead = 1'b0;
    int   busy_min = 2;
    int   busy_max = 6;
    int   uart_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ld_tx_data && !tx_busy && !uart_dead) begin
            tx_busy   <= 1'b1;
            uart_left <= int'($urandom_range(busy_max, busy_min));
        end else if (tx_busy) begin
            if (uart_left <= 1) tx_busy <= 1'b0;
            else                uart_left <= uart_left - 1;
        end
    end

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference packet built arithmetically from the field layout
    function automatic exp_t make_exp(input logic op, input logic [7:0] chip, input logic [7:0] addr,
                                      input logic [7:0] data, input logic bdp);
        exp_t        e;
        logic [63:0] v;
        v = op ? 64'd3 : 64'd2;
        v = v + 64'(chip) * 64'd4;
        v = v + 64'(addr) * 64'd1024;
        if (!op) v = v + 64'(data) * 64'd262144;
        v = v + 64'(MAGIC) * 64'd67108864;
        if ($countones(v) % 2 == 0) v = v + 64'h8000_0000_0000_0000;
        if (bdp) v = v ^ 64'h8000_0000_0000_0000;
        e.pkt = v; e.op = op; e.chip = chip; e.addr = addr; e.data = data; e.bdp = bdp;
        return e;
    endfunction

    // Monitor: compares every load against the scoreboard and watches handshake rules
    initial begin : monitor
        exp_t e;
        logic prev_ld = 1'b0;
        logic prev_busy = 1'b0;
        bit   have_fall = 1'b0;
        int   fall_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ready_vs_full", 64'(req_if.req_ready), 64'(fifo_count != CW'(FIFO_DEPTH)));
                if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
                if (prev_busy && !tx_busy) begin
                    fall_cyc  = cyc;
                    have_fall = 1'b1;
                end
                if (ld_tx_data) begin
                    ld_seen++;
                    last_ld_cyc = cyc;
                    check("ld_while_busy", 64'(tx_busy), 64'd0);
                    check("ld_one_cycle", 64'(prev_ld), 64'd0);
                    if (have_fall) check("gap_after_busy", 64'(cyc - fall_cyc > GAP_CYCLES), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL unexpected_load: got pkt=0x%0h expected no load", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("packet", tx_data, e.pkt);
                        check("rx_type", 64'(tx_data[1:0]), e.op ? 64'd3 : 64'd2);
                        check("rx_chip", 64'(tx_data[9:2]), 64'(e.chip));
                        check("rx_addr", 64'(tx_data[17:10]), 64'(e.addr));
                        check("rx_data", 64'(tx_data[25:18]), e.op ? 64'd0 : 64'(e.data));
                        check("rx_magic", 64'(tx_data[57:26]), 64'(MAGIC));
                        check("rx_pad", 64'(tx_data[62:58]), 64'd0);
                        check("rx_parity_error", 64'($countones(tx_data) % 2 == 0), 64'(e.bdp));
                    end
                end
            end
            prev_ld   = ld_tx_data;
            prev_busy = tx_busy;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Drive one request from a negedge; returns at the negedge after acceptance
    task automatic send(input logic op, input logic [7:0] chip, input logic [7:0] addr,
                        input logic [7:0] data, input logic bdp, input bit hold);
        int waited = 0;
        req_if.req_valid      = 1'b1;
        req_if.req_op         = op;
        req_if.req_chip_id    = chip;
        req_if.req_addr       = addr;
        req_if.req_data       = data;
        req_if.req_bad_parity = bdp;
        while (!req_if.req_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!req_if.req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_if.req_valid = 1'b0;
            return;
        end
        exp_q.push_back(make_exp(op, chip, addr, data, bdp));
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) req_if.req_valid = 1'b0;
    endtask

    task automatic wait_ld(input int seen_before);
        int k = 0;
        while (ld_seen == seen_before && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (ld_seen == seen_before) check("ld_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_quiet();
        int k = 0;
        while (!(idle && !tx_busy && exp_q.size() == 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) check("quiet_wait_timeout", 64'd0, 64'd1);
        repeat (GAP_CYCLES + 2) @(negedge clk);
    endtask

    initial begin : stimulus
        int seen;
        int l;
        int k;
        req_if.req_valid = 1'b0; req_if.req_op = 1'b0; req_if.req_chip_id = 8'd0;
        req_if.req_addr = 8'd0; req_if.req_data = 8'd0; req_if.req_bad_parity = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 64'd0);
        check("rst_ld", 64'(ld_tx_data), 64'd0);
        check("rst_ready", 64'(req_if.req_ready), 64'd1);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_sent", 64'(pkt_sent_count), 64'd0);
        check("rst_to_err", 64'(timeout_err), 64'd0);
        check("rst_to_count", 64'(timeout_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single write: fields checked by the monitor, latency here
        seen = ld_seen;
        send(1'b0, 8'd0, 8'h40, 8'h10, 1'b0, 1'b0);
        wait_ld(seen);
        check("load_latency", 64'(last_ld_cyc - acc_cyc), 64'd2);
        exp_sent++;
        wait_quiet();
        check("sent_after_write", 64'(pkt_sent_count), 64'(exp_sent));

        // Broadcast read: data forced to zero
        send(1'b1, GLOBAL_ID, 8'h05, 8'hAA, 1'b0, 1'b0);
        exp_sent++;
        wait_quiet();
        check("sent_after_read", 64'(pkt_sent_count), 64'(exp_sent));

        // Burst of 10 with valid held against a slow UART
        busy_min = 30; busy_max = 40; max_count = 0;
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 8'(i), 8'(8'h20 + i), 8'($urandom), 1'b0, i != 9);
        end
        exp_sent += 10;
        wait_quiet();
        check("burst_max_count", 64'(max_count), 64'(FIFO_DEPTH));
        check("sent_after_burst", 64'(pkt_sent_count), 64'(exp_sent));

        // Parity error injection
        busy_min = 2; busy_max = 6;
        send(1'b0, 8'd3, 8'h11, 8'h22, 1'b1, 1'b0);
        exp_sent++;
        wait_quiet();

        // UART never answers the first load; the queued second one still goes out
        uart_dead = 1'b1;
        seen = ld_seen;
        send(1'b0, 8'd7, 8'h01, 8'h5A, 1'b0, 1'b1);
        send(1'b1, 8'd8, 8'h02, 8'h00, 1'b0, 1'b0);
        wait_ld(seen);
        l = last_ld_cyc;
        @(posedge clk);
        @(negedge clk);
        uart_dead = 1'b0;
        while (cyc < l + BUSY_TIMEOUT - 2) @(negedge clk);
        check("to_err_early", 64'(timeout_err), 64'd0);
        while (cyc < l + BUSY_TIMEOUT) @(negedge clk);
        check("to_err_set", 64'(timeout_err), 64'd1);
        check("to_count_one", 64'(timeout_count), 64'd1);
        exp_sent++;
        wait_quiet();
        check("sent_after_timeout", 64'(pkt_sent_count), 64'(exp_sent));
        check("to_err_sticky", 64'(timeout_err), 64'd1);

        // Reset while the UART is busy with three requests still queued
        busy_min = 60; busy_max = 60;
        seen = ld_seen;
        for (int i = 0; i < 4; i++) send(1'b0, 8'(40 + i), 8'(i), 8'(i * 3), 1'b0, i != 3);
        wait_ld(seen);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 64'(tx_busy), 64'd1);
        check("pre_rst_fifo", 64'(fifo_count), 64'd3);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_fifo", 64'(fifo_count), 64'd0);
        check("mid_rst_idle", 64'(idle), 64'd1);
        check("mid_rst_ld", 64'(ld_tx_data), 64'd0);
        check("mid_rst_sent", 64'(pkt_sent_count), 64'd0);
        check("mid_rst_to_err", 64'(timeout_err), 64'd0);
        check("mid_rst_to_count", 64'(timeout_count), 64'd0);
        reset = 1'b0;
        exp_sent = 0;
        k = 0;
        while (tx_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (GAP_CYCLES + 2) @(negedge clk);
        busy_min = 2; busy_max = 6;
        send(1'b0, 8'd9, 8'h33, 8'h44, 1'b0, 1'b0);
        exp_sent++;
        wait_quiet();
        check("sent_after_reset", 64'(pkt_sent_count), 64'(exp_sent));

        // Randomized traffic
        busy_min = 2; busy_max = 12;
        for (int i = 0; i < 24; i++) begin
            send(1'($urandom), ($urandom_range(0, 3) == 0) ? GLOBAL_ID : 8'($urandom),
                 8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        req_if.req_valid = 1'b0;
        exp_sent += 24;
        wait_quiet();
        check("sent_final", 64'(pkt_sent_count), 64'(exp_sent));
        check("to_count_final", 64'(timeout_count), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
